// File: rtl/int_request_ctrl.sv
// int_request_ctrl: CPU interrupt requester with sync/edge detect, pending latch, priority pick and ack/done handshake.
// Optional source masking via `define INT_MASK_EN (adds IRQ_MASK). A line already high at reset release is counted as a rise.
module int_request_ctrl #(
  parameter int NUM_SRC = 4,
  parameter int VEC_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic [NUM_SRC-1:0] IRQ_IN,
  input  logic               I_EN,
  input  logic               INT_ACK,
  input  logic               INT_DONE,
`ifdef INT_MASK_EN
  input  logic [NUM_SRC-1:0] IRQ_MASK,
`endif
  output logic               INTR,
  output logic [VEC_W-1:0]   INT_VEC,
  output logic [NUM_SRC-1:0] PENDING,
  output logic               IN_SERVICE
);
  typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;
  state_t state_q, state_d;
  logic [NUM_SRC-1:0] sync1_q, sync2_q, prev_q, pending_q, pending_d, rise, elig, clr;
  logic intr_q, intr_d, svc_q, svc_d, win_vld;
  logic [VEC_W-1:0] vec_q, vec_d, win_idx;
  assign rise = sync2_q & ~prev_q;
`ifdef INT_MASK_EN
  assign elig = pending_q & IRQ_MASK;
`else
  assign elig = pending_q;
`endif
  assign win_vld = |elig;
  always_comb begin
    win_idx = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--)
      if (elig[i]) win_idx = VEC_W'(i);
  end
  always_comb begin
    state_d = state_q;
    intr_d  = intr_q;
    vec_d   = vec_q;
    svc_d   = svc_q;
    clr     = '0;
    case (state_q)
      IDLE:
        if (win_vld && I_EN) begin
          state_d = REQ;
          intr_d  = 1'b1;
          vec_d   = win_idx;
        end
      REQ:
        if (INT_ACK) begin
          state_d = SERVICE;
          intr_d  = 1'b0;
          svc_d   = 1'b1;
          clr     = NUM_SRC'(1) << vec_q;
        end else if (!I_EN) begin
          state_d = IDLE;
          intr_d  = 1'b0;
        end
      SERVICE:
        if (INT_DONE) begin
          state_d = IDLE;
          svc_d   = 1'b0;
        end
      default: state_d = IDLE;
    endcase
    // a fresh edge in the ack cycle survives the clear
    pending_d = (pending_q & ~clr) | rise;
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      pending_q <= '0;
      state_q   <= IDLE;
      intr_q    <= 1'b0;
      vec_q     <= '0;
      svc_q     <= 1'b0;
    end else begin
      sync1_q   <= IRQ_IN;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
      pending_q <= pending_d;
      state_q   <= state_d;
      intr_q    <= intr_d;
      vec_q     <= vec_d;
      svc_q     <= svc_d;
    end
  end
  assign INTR       = intr_q;
  assign INT_VEC    = vec_q;
  assign PENDING    = pending_q;
  assign IN_SERVICE = svc_q;
endmodule
